axis_homing_responder: RTL and testbench
========================================

Name: axis_homing_responder

Overview:
- Responder side of the pre-print homing handshake: the motor-sequencing FSM raises one axis command; this block steps that axis toward home and returns the limit-switch level (sz, sx, sy) that the sequencer waits on.
- Replaces fixed-delay homing stand-ins with a cycle-accurate axis model: per-axis position counters, step-rate divider, one-hot step pulses.
- Used both as the bench model for the sequencer and as the step-pulse front end toward the stepper drivers.

Parameters:
- POS_W, 8, width of each axis position counter.
- STEP_DIV, 4, clocks per step; legal range 2..255.
- INIT_Z, 5, Z position loaded at reset; must be < 2**POS_W.
- INIT_X, 3, X position loaded at reset; must be < 2**POS_W.
- INIT_Y, 4, Y position loaded at reset; must be < 2**POS_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears or initialises all state.
- mot_cmd  in  3  home request, one-hot: [0]=Z, [1]=X, [2]=Y.
- load_axis  in  3  one-hot position preload strobe: [0]=Z, [1]=X, [2]=Y.
- load_pos  in  POS_W  preload value.
- step  out  3  one-cycle step pulse per axis, same bit order as mot_cmd.
- sz  out  1  Z limit switch, high iff pos_z == 0.
- sx  out  1  X limit switch, high iff pos_x == 0.
- sy  out  1  Y limit switch, high iff pos_y == 0.
- busy  out  1  high while in MOVE.
- err  out  1  high while in IDLE with more than one mot_cmd bit set.
- pos_z, pos_x, pos_y  out  POS_W each  current axis positions.

Behaviour:
- Reset (async, active-high): state=IDLE; pos_z/x/y = INIT_Z/X/Y; div=0; axis latch=0; step=000; busy=0; err=0. Limits follow positions.
- Limit outputs are combinational compares on flopped positions. They are glitch-free and change only on the clock edge that changes the position.
- State IDLE:
  - Exactly one mot_cmd bit set and that axis position != 0: latch the axis, div<=0, next state MOVE.
  - Exactly one mot_cmd bit set and that axis position == 0: next state HOME directly, with no step issued.
  - Zero bits set: stay in IDLE.
  - More than one bit set: stay in IDLE; err=1 combinationally. No motion, no latch.
- State MOVE:
  - busy=1. Each edge: if div == STEP_DIV-1, then step <= latched one-hot, latched pos <= pos-1, div <= 0; else step <= 000, div <= div+1.
  - If the decrement takes pos to 0, next state HOME. The step pulse and the limit rising appear together in the same cycle.
  - If the latched mot_cmd bit is low at an edge: next state IDLE, step <= 000, no decrement on that edge, position held.
  - Changes on other mot_cmd bits during MOVE are ignored.
- State HOME:
  - busy=0; step=000.
  - Stay until the latched mot_cmd bit drops, then go to IDLE.
- Latency: first step appears STEP_DIV+1 edges after the edge that samples mot_cmd in IDLE. Subsequent steps are every STEP_DIV edges. Homing from position N completes 1+N*STEP_DIV edges after the request is sampled.
- Preload:
  - Honoured only in IDLE. Each set load_axis bit writes load_pos to its axis on that edge; several bits may be set at once.
  - In MOVE or HOME, load_axis is ignored.
  - When load and a valid mot_cmd coincide in IDLE, the load wins for that edge and the transition to MOVE is deferred one edge, so the move uses the new position.
- Arithmetic: positions are unsigned and only decremented. No underflow is possible because MOVE never runs with pos == 0. No wrap.
- Reset mid-MOVE: immediate abort to the reset values; positions return to INIT_* (they are not held).
- step is a registered output with no combinational path from inputs. err and the limits are the only combinational outputs.

Test Plan:
- Defaults, reset released, mot_cmd=010 sampled at edge E → step[1] pulses at E+5, E+9, E+13; pos_x goes 2,1,0; sx rises at E+13; busy high from E+1 to E+13; steps on other axes stay 0.
- Z homing with mot_cmd=001 dropped to 000 after the second step (pos_z=3) → return to IDLE, pos_z holds 3, no further steps. Re-assert → three more steps, sz=1.
- load_axis=100, load_pos=0 in IDLE, then mot_cmd=100 → sy=1 immediately after load; next state HOME with zero step pulses; busy stays 0.
- mot_cmd=011 in IDLE → err=1, no step, positions unchanged. Change to 001 → err=0, Z homing begins.
- Assert reset asynchronously mid-X move (pos_x=1) → outputs clear without waiting for a clock edge; pos_x=3; sx=0; state IDLE.
- load_axis=010 with load_pos=255 during MOVE on Z → ignored, pos_x unchanged. Load applied in IDLE together with mot_cmd=010 → 255 steps; sx rises after 1+255*4 edges.

Source files
------------

// File: rtl/axis_homing_responder.sv
// Homing responder: steps one commanded axis toward zero at a fixed clock divide
// and reports the per-axis limit switches back to the motor sequencer.
module axis_homing_responder #(
  parameter int unsigned POS_W    = 8,
  parameter int unsigned STEP_DIV = 4,
  parameter int unsigned INIT_Z   = 5,
  parameter int unsigned INIT_X   = 3,
  parameter int unsigned INIT_Y   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mot_cmd,
  input  logic [2:0]       load_axis,
  input  logic [POS_W-1:0] load_pos,
  output logic [2:0]       step,
  output logic             sz,
  output logic             sx,
  output logic             sy,
  output logic             busy,
  output logic             err,
  output logic [POS_W-1:0] pos_z,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    HOME = 2'd2
  } state_t;

  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [7:0]       DIV_LAST = 8'(STEP_DIV - 1);
  localparam logic [7:0]       DIV_ONE  = 8'd1;

  state_t           state, state_next;
  logic [2:0]       axis_q;
  logic [7:0]       div;
  logic [POS_W-1:0] cmd_pos;
  logic [POS_W-1:0] axis_pos;
  logic             cmd_one_hot;
  logic             cmd_multi;
  logic             cmd_held;

  assign cmd_one_hot = (mot_cmd == 3'b001) || (mot_cmd == 3'b010) || (mot_cmd == 3'b100);
  assign cmd_multi   = (mot_cmd != 3'b000) && !cmd_one_hot;
  assign cmd_held    = |(mot_cmd & axis_q);

  assign sz = (pos_z == '0);
  assign sx = (pos_x == '0);
  assign sy = (pos_y == '0);

  // Position of the axis being requested (IDLE) and of the axis being moved.
  always_comb begin
    cmd_pos  = '0;
    axis_pos = '0;
    case (mot_cmd)
      3'b001:  cmd_pos = pos_z;
      3'b010:  cmd_pos = pos_x;
      3'b100:  cmd_pos = pos_y;
      default: cmd_pos = '0;
    endcase
    case (axis_q)
      3'b001:  axis_pos = pos_z;
      3'b010:  axis_pos = pos_x;
      3'b100:  axis_pos = pos_y;
      default: axis_pos = '0;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    err        = 1'b0;
    case (state)
      IDLE: begin
        err = cmd_multi;
        // A preload on the same edge defers the move so it sees the new position.
        if (load_axis == 3'b000 && cmd_one_hot)
          state_next = (cmd_pos == '0) ? HOME : MOVE;
      end
      MOVE: begin
        if (!cmd_held)
          state_next = IDLE;
        else if (busy && div == DIV_LAST && axis_pos == POS_ONE)
          state_next = HOME;
      end
      HOME: begin
        if (!cmd_held)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all state here is updated with non-blocking assignments so every flop
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pos_z  <= POS_W'(INIT_Z);
      pos_x  <= POS_W'(INIT_X);
      pos_y  <= POS_W'(INIT_Y);
      div    <= '0;
      axis_q <= '0;
      step   <= '0;
      busy   <= 1'b0;
    end else begin
      state <= state_next;
      step  <= '0;
      // busy rises on the first MOVE edge; the divider only runs once it is up,
      // which gives the one-edge setup before the first step.
      busy  <= (state == MOVE) && (state_next == MOVE);
      case (state)
        IDLE: begin
          if (load_axis[0]) pos_z <= load_pos;
          if (load_axis[1]) pos_x <= load_pos;
          if (load_axis[2]) pos_y <= load_pos;
          if (state_next != IDLE) begin
            axis_q <= mot_cmd;
            div    <= '0;
          end
        end
        MOVE: begin
          if (state_next != IDLE && busy) begin
            if (div == DIV_LAST) begin
              step <= axis_q;
              div  <= '0;
              if (axis_q[0]) pos_z <= pos_z - POS_ONE;
              if (axis_q[1]) pos_x <= pos_x - POS_ONE;
              if (axis_q[2]) pos_y <= pos_y - POS_ONE;
            end else begin
              div <= div + DIV_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_homing_responder.sv
// Scoreboard bench for axis_homing_responder: stimulus queues expected step pulses,
// a negedge monitor pops one per observed pulse and checks timing and position.
module tb_axis_homing_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] mot_cmd;
  logic [2:0] load_axis;
  logic [7:0] load_pos;
  logic [2:0] step;
  logic       sz, sx, sy, busy, err;
  logic [7:0] pos_z, pos_x, pos_y;

  axis_homing_responder #(
    .POS_W(8), .STEP_DIV(4), .INIT_Z(5), .INIT_X(3), .INIT_Y(4)
  ) dut (
    .clk(clk), .reset(reset), .mot_cmd(mot_cmd), .load_axis(load_axis),
    .load_pos(load_pos), .step(step), .sz(sz), .sx(sx), .sy(sy),
    .busy(busy), .err(err), .pos_z(pos_z), .pos_x(pos_x), .pos_y(pos_y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] step;
    logic [7:0] pos;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Steps from start_pos: first at e+5, then every 4 edges, position after each.
  task automatic push_steps(input int ev, input logic [2:0] ax, input int start_pos, input int n);
    for (int k = 0; k < n; k++)
      q.push_back('{ev + 5 + 4 * k, ax, 8'(start_pos - 1 - k)});
  endtask

  always @(negedge clk) begin : monitor
    exp_t       ex;
    logic [7:0] act_pos;
    if (!reset && step != 3'b000) begin
      n_vec++;
      act_pos = step[0] ? pos_z : (step[1] ? pos_x : pos_y);
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_step: got step=%b at cycle %0d, expected none", step, cyc);
      end else begin
        ex = q.pop_front();
        if (step !== ex.step || cyc != ex.cyc || act_pos !== ex.pos) begin
          n_err++;
          $display("FAIL step_pulse: got step=%b cycle=%0d pos=%0d, expected step=%b cycle=%0d pos=%0d",
                   step, cyc, act_pos, ex.step, ex.cyc, ex.pos);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mot_cmd = 3'b000; load_axis = 3'b000; load_pos = 8'd0;
    #12;
    check("reset_pos_z", pos_z, 5);
    check("reset_pos_x", pos_x, 3);
    check("reset_pos_y", pos_y, 4);
    check("reset_step", step, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    check("reset_limits", {sz, sx, sy}, 0);
    tick(2);
    reset = 1'b0;
    tick(1);

    // X homing from 3
    mot_cmd = 3'b010; e = cyc + 1;
    push_steps(e, 3'b010, 3, 3);
    tick(2);
    check("x_busy_rise", busy, 1);
    tick(e + 12 - cyc);
    check("x_busy_before_home", busy, 1);
    check("x_sx_before_home", sx, 0);
    tick(1);
    check("x_sx_home", sx, 1);
    check("x_busy_home", busy, 0);
    check("x_other_axes", {pos_z, pos_y}, {8'd5, 8'd4});
    mot_cmd = 3'b000;
    tick(2);

    // Z partial move, abort, then resume
    mot_cmd = 3'b001; e = cyc + 1;
    push_steps(e, 3'b001, 5, 2);
    tick(e + 9 - cyc);
    check("z_mid_pos", pos_z, 3);
    mot_cmd = 3'b000;
    tick(4);
    check("z_abort_hold", pos_z, 3);
    check("z_abort_busy", busy, 0);
    mot_cmd = 3'b001; e = cyc + 1;
    push_steps(e, 3'b001, 3, 3);
    tick(e + 13 - cyc);
    check("z_resume_sz", sz, 1);
    mot_cmd = 3'b000;
    tick(2);

    // Y preload to 0, then request: straight to HOME with no steps
    load_axis = 3'b100; load_pos = 8'd0;
    tick(1);
    load_axis = 3'b000;
    check("y_load_sy", sy, 1);
    mot_cmd = 3'b100;
    tick(6);
    check("y_home_busy", busy, 0);
    check("y_home_step", step, 0);
    mot_cmd = 3'b000;
    tick(2);

    // Multi-bit command flags err and does nothing
    load_axis = 3'b001; load_pos = 8'd2;
    tick(1);
    load_axis = 3'b000;
    check("z_load2", pos_z, 2);
    mot_cmd = 3'b011;
    #1 check("err_set", err, 1);
    tick(3);
    check("err_hold", err, 1);
    check("err_no_motion", {pos_z, pos_x}, {8'd2, 8'd0});
    check("err_busy", busy, 0);
    mot_cmd = 3'b001;
    #1 check("err_clear", err, 0);
    e = cyc + 1;
    push_steps(e, 3'b001, 2, 2);
    tick(e + 9 - cyc);
    check("err_then_z_sz", sz, 1);
    mot_cmd = 3'b000;
    tick(2);

    // Load coincident with command defers the move; then async reset mid-move
    load_axis = 3'b010; load_pos = 8'd3; mot_cmd = 3'b010;
    tick(1);
    load_axis = 3'b000; e = cyc + 1;
    push_steps(e, 3'b010, 3, 2);
    tick(e + 9 - cyc);
    check("x_before_reset", pos_x, 1);
    #2 reset = 1'b1;
    #1;
    check("areset_pos_x", pos_x, 3);
    check("areset_sx", sx, 0);
    check("areset_busy", busy, 0);
    check("areset_step", step, 0);
    check("areset_pos_zy", {pos_z, pos_y}, {8'd5, 8'd4});
    mot_cmd = 3'b000;
    @(negedge clk) reset = 1'b0;
    tick(1);

    // Z move with an X preload attempt that must be ignored
    mot_cmd = 3'b001; e = cyc + 1;
    push_steps(e, 3'b001, 5, 5);
    tick(e + 3 - cyc);
    load_axis = 3'b010; load_pos = 8'd255;
    tick(1);
    load_axis = 3'b000;
    tick(e + 21 - cyc);
    check("ignored_load_pos_x", pos_x, 3);
    check("z_full_sz", sz, 1);
    mot_cmd = 3'b000;
    tick(2);

    // Preload 255 with simultaneous command: 255 steps
    load_axis = 3'b010; load_pos = 8'd255; mot_cmd = 3'b010;
    tick(1);
    load_axis = 3'b000; e = cyc + 1;
    push_steps(e, 3'b010, 255, 255);
    tick(e + 1020 - cyc);
    check("x255_sx_before", sx, 0);
    check("x255_pos_before", pos_x, 1);
    tick(1);
    check("x255_sx_home", sx, 1);
    check("x255_busy", busy, 0);
    mot_cmd = 3'b000;
    tick(4);
    check("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
